// File: rtl/huff_pkg.sv
// Shared types for the code-length Huffman table builder: sequencer states,
// error codes and default field widths.
package huff_pkg;

  localparam int DEF_INDEX_BIT = 4;
  localparam int DEF_LEN_BIT   = 3;
  localparam int DEF_MAX_LEN   = 7;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    COUNT,
    CHECK,
    NEXTCODE,
    ASSIGN_ADDR,
    ASSIGN_WAIT,
    ASSIGN_USE,
    DONE,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_COUNT   = 2'd1,
    ERR_OVERSUB = 2'd2,
    ERR_EMPTY   = 2'd3
  } err_t;

endpackage

// File: rtl/huff_next_code.sv
// Canonical first-code register file: runs the per-length code recurrence,
// flags an oversubscribed length set and hands out codes during assignment.
module huff_next_code
  import huff_pkg::*;
#(
  parameter int LEN_BIT   = DEF_LEN_BIT,
  parameter int COUNT_BIT = 5,
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int CODE_BIT  = DEF_MAX_LEN
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   step,
  input  logic [LEN_BIT-1:0]     bits,
  input  logic [16*COUNT_BIT-1:0] bl_count,
  output logic                   oversub,
  input  logic [LEN_BIT-1:0]     rd_len,
  input  logic                   inc,
  output logic [CODE_BIT-1:0]    rd_code
);

  // One extra bit so a full code space (2^bits) and the overflow compare are representable.
  localparam int W = CODE_BIT + 1;

  logic [W-1:0] code_acc;
  logic [W-1:0] code_new;
  logic [W-1:0] prev_cnt;
  logic [W-1:0] cur_cnt;
  logic [W-1:0] limit;
  logic [W-1:0] next_code [MAX_LEN+1];
  logic         unused_counts;

  // Length 0 never takes part in the recurrence, so its count is forced to zero.
  always_comb begin
    prev_cnt = '0;
    if (bits > LEN_BIT'(1))
      prev_cnt = W'(bl_count[(int'(bits) - 1) * COUNT_BIT +: COUNT_BIT]);
    cur_cnt  = W'(bl_count[int'(bits) * COUNT_BIT +: COUNT_BIT]);
    code_new = (code_acc + prev_cnt) << 1;
    limit    = W'(1) << bits;
    oversub  = step && ((code_new + cur_cnt) > limit);
  end

  // NOTE: this register file is small and read right after a reset-abort, so it
  // is reset explicitly instead of relying on NEXTCODE to overwrite it.
  always_ff @(posedge clock) begin
    if (reset) begin
      code_acc <= '0;
      for (int i = 0; i <= MAX_LEN; i++) next_code[i] <= '0;
    end else begin
      if (init) begin
        code_acc <= '0;
      end else if (step) begin
        code_acc        <= code_new;
        next_code[bits] <= code_new;
      end
      if (inc) next_code[rd_len] <= next_code[rd_len] + W'(1);
    end
  end

  assign rd_code       = next_code[rd_len][CODE_BIT-1:0];
  assign unused_counts = ^bl_count[16*COUNT_BIT-1:(MAX_LEN+1)*COUNT_BIT];

endmodule

// File: rtl/huff_build_ctrl.sv
// Sequencer that runs the length histogram, derives canonical first codes and
// streams one (symbol, code, length) write per coded symbol to the code table.
module huff_build_ctrl
  import huff_pkg::*;
#(
  parameter int INDEX_BIT   = DEF_INDEX_BIT,
  parameter int LEN_BIT     = DEF_LEN_BIT,
  parameter int COUNT_BIT   = 5,
  parameter int LEN_ADDRESS = 6,
  parameter int INDEX_COUNT = 19,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int CODE_BIT    = MAX_LEN
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_BIT+INDEX_BIT-1:0] in_data,
  output logic [LEN_ADDRESS-1:0]       mem_add,
  output logic                         mem_ena,
  output logic                         mem_wea,
  output logic                         cnt_reset,
  input  logic [LEN_ADDRESS-1:0]       cnt_add,
  input  logic                         cnt_ena,
  input  logic                         cnt_sig_end,
  input  logic                         cnt_error,
  input  logic [COUNT_BIT-1:0]         cnt_max,
  input  logic [16*COUNT_BIT-1:0]      bl_count,
  output logic                         code_we,
  output logic [LEN_ADDRESS-1:0]       code_addr,
  output logic [CODE_BIT-1:0]          code_val,
  output logic [LEN_BIT-1:0]           code_len,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   error
);

  state_t state, state_next;
  err_t   err_q, err_next;

  logic [LEN_BIT-1:0]     bits;
  logic [LEN_ADDRESS-1:0] sym;
  logic [LEN_BIT-1:0]     rd_len;
  logic [CODE_BIT-1:0]    rd_code;
  logic                   oversub;
  logic                   nc_inc;
  logic                   last_sym;
  logic                   unused_index;

  assign rd_len       = in_data[LEN_BIT-1:0];
  assign unused_index = ^in_data[LEN_BIT+INDEX_BIT-1:LEN_BIT];
  assign last_sym     = (sym == LEN_ADDRESS'(INDEX_COUNT - 1));
  assign nc_inc       = (state == ASSIGN_USE) && (rd_len != '0);

  huff_next_code #(
    .LEN_BIT  (LEN_BIT),
    .COUNT_BIT(COUNT_BIT),
    .MAX_LEN  (MAX_LEN),
    .CODE_BIT (CODE_BIT)
  ) u_next_code (
    .clock   (clock),
    .reset   (reset),
    .init    (state == CHECK),
    .step    (state == NEXTCODE),
    .bits    (bits),
    .bl_count(bl_count),
    .oversub (oversub),
    .rd_len  (rd_len),
    .inc     (nc_inc),
    .rd_code (rd_code)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    err_next   = err_q;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_next = CLEAR;
          err_next   = ERR_NONE;
        end
      end
      CLEAR: state_next = COUNT;
      COUNT: if (cnt_sig_end) state_next = CHECK;
      CHECK: begin
        if (cnt_error) begin
          state_next = FAIL;
          err_next   = ERR_COUNT;
        end else if (cnt_max == '0) begin
          state_next = FAIL;
          err_next   = ERR_EMPTY;
        end else begin
          state_next = NEXTCODE;
        end
      end
      NEXTCODE: begin
        if (oversub) begin
          state_next = FAIL;
          err_next   = ERR_OVERSUB;
        end else if (bits == LEN_BIT'(MAX_LEN)) begin
          state_next = ASSIGN_ADDR;
        end
      end
      ASSIGN_ADDR: state_next = ASSIGN_WAIT;
      ASSIGN_WAIT: state_next = ASSIGN_USE;
      ASSIGN_USE:  state_next = last_sym ? DONE : ASSIGN_ADDR;
      default:     state_next = IDLE;
    endcase
  end

  // The histogram stage owns the RAM port while counting; the sequencer owns it while assigning.
  always_comb begin
    mem_add = '0;
    mem_ena = 1'b0;
    case (state)
      COUNT: begin
        mem_add = cnt_add;
        mem_ena = cnt_ena;
      end
      ASSIGN_ADDR: begin
        mem_add = sym;
        mem_ena = 1'b1;
      end
      ASSIGN_WAIT, ASSIGN_USE: mem_add = sym;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      err_q     <= ERR_NONE;
      bits      <= '0;
      sym       <= '0;
      code_we   <= 1'b0;
      code_addr <= '0;
      code_val  <= '0;
      code_len  <= '0;
    end else begin
      state   <= state_next;
      err_q   <= err_next;
      code_we <= nc_inc;
      if (state == CHECK)         bits <= LEN_BIT'(1);
      else if (state == NEXTCODE) bits <= bits + LEN_BIT'(1);
      if (state == CHECK)           sym <= '0;
      else if (state == ASSIGN_USE) sym <= sym + LEN_ADDRESS'(1);
      if (nc_inc) begin
        code_addr <= sym;
        code_val  <= rd_code;
        code_len  <= rd_len;
      end
    end
  end

  assign busy      = !(state inside {IDLE, DONE, FAIL});
  assign done      = (state == DONE);
  assign error     = err_q;
  assign cnt_reset = reset | (state == CLEAR);
  assign mem_wea   = 1'b0;

endmodule

// File: tb/tb_huff_build_ctrl.sv
// Self-checking bench: emulates the length RAM and histogram stage, predicts
// strobes, errors and latency from canonical-code rules.
module tb_huff_build_ctrl;

  localparam int INDEX_BIT   = 4;
  localparam int LEN_BIT     = 3;
  localparam int COUNT_BIT   = 5;
  localparam int LEN_ADDRESS = 6;
  localparam int INDEX_COUNT = 19;
  localparam int MAX_LEN     = 7;
  localparam int CODE_BIT    = 7;

  logic                         clock;
  logic                         reset;
  logic                         start;
  logic [LEN_BIT+INDEX_BIT-1:0] in_data;
  logic [LEN_ADDRESS-1:0]       mem_add;
  logic                         mem_ena;
  logic                         mem_wea;
  logic                         cnt_reset;
  logic [LEN_ADDRESS-1:0]       cnt_add;
  logic                         cnt_ena;
  logic                         cnt_sig_end;
  logic                         cnt_error;
  logic [COUNT_BIT-1:0]         cnt_max;
  logic [16*COUNT_BIT-1:0]      bl_count;
  logic                         code_we;
  logic [LEN_ADDRESS-1:0]       code_addr;
  logic [CODE_BIT-1:0]          code_val;
  logic [LEN_BIT-1:0]           code_len;
  logic                         busy;
  logic                         done;
  logic [1:0]                   error;

  huff_build_ctrl #(
    .INDEX_BIT(INDEX_BIT), .LEN_BIT(LEN_BIT), .COUNT_BIT(COUNT_BIT),
    .LEN_ADDRESS(LEN_ADDRESS), .INDEX_COUNT(INDEX_COUNT),
    .MAX_LEN(MAX_LEN), .CODE_BIT(CODE_BIT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .mem_add(mem_add), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .cnt_reset(cnt_reset), .cnt_add(cnt_add), .cnt_ena(cnt_ena),
    .cnt_sig_end(cnt_sig_end), .cnt_error(cnt_error), .cnt_max(cnt_max),
    .bl_count(bl_count), .code_we(code_we), .code_addr(code_addr),
    .code_val(code_val), .code_len(code_len), .busy(busy), .done(done),
    .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [LEN_ADDRESS-1:0] addr;
    logic [CODE_BIT-1:0]    code;
    logic [LEN_BIT-1:0]     len;
  } strobe_t;

  logic [LEN_BIT-1:0]           lens [INDEX_COUNT];
  logic [LEN_BIT+INDEX_BIT-1:0] ram_q;
  strobe_t                      got[$];
  strobe_t                      exp_q[$];
  strobe_t                      mon_st;
  int                           exp_err;
  int                           exp_lat;
  int                           checks = 0;
  int                           errors = 0;

  // Length RAM with one-cycle registered read.
  always @(posedge clock) begin
    if (mem_ena) begin
      if (int'(mem_add) < INDEX_COUNT) ram_q <= {INDEX_BIT'(mem_add), lens[int'(mem_add)]};
      else ram_q <= '0;
    end
  end
  assign in_data = ram_q;

  always @(negedge clock) begin
    if (code_we) begin
      mon_st.addr = code_addr;
      mon_st.code = code_val;
      mon_st.len  = code_len;
      got.push_back(mon_st);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outcome from Kraft prefix sums and sorted canonical assignment.
  task automatic build_model(input bit force_err);
    int      cnt [MAX_LEN+1];
    int      codes [INDEX_COUNT];
    int      code, prev_len, acc, maxl, fail_b;
    strobe_t st;
    exp_q.delete();
    for (int l = 0; l <= MAX_LEN; l++) cnt[l] = 0;
    maxl = 0;
    for (int s = 0; s < INDEX_COUNT; s++) begin
      if (lens[s] != 0) cnt[lens[s]]++;
      if (int'(lens[s]) > maxl) maxl = int'(lens[s]);
    end
    fail_b = 0;
    for (int b = 1; b <= MAX_LEN; b++) begin
      acc = 0;
      for (int l = 1; l <= b; l++) acc += cnt[l] << (b - l);
      if (acc > (1 << b) && fail_b == 0) fail_b = b;
    end
    if (force_err) begin
      exp_err = 1; exp_lat = 2;
    end else if (maxl == 0) begin
      exp_err = 3; exp_lat = 2;
    end else if (fail_b != 0) begin
      exp_err = 2; exp_lat = 2 + fail_b;
    end else begin
      exp_err = 0; exp_lat = 2 + MAX_LEN + 3 * INDEX_COUNT;
      code = 0; prev_len = 0;
      for (int l = 1; l <= MAX_LEN; l++)
        for (int s = 0; s < INDEX_COUNT; s++)
          if (int'(lens[s]) == l) begin
            code = code << (l - prev_len);
            codes[s] = code;
            code++;
            prev_len = l;
          end
      for (int s = 0; s < INDEX_COUNT; s++)
        if (lens[s] != 0) begin
          st.addr = LEN_ADDRESS'(s);
          st.code = CODE_BIT'(codes[s]);
          st.len  = lens[s];
          exp_q.push_back(st);
        end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_code_we"}, code_we, 0);
    check({tag, "_code_addr"}, code_addr, 0);
    check({tag, "_code_val"}, code_val, 0);
    check({tag, "_code_len"}, code_len, 0);
    check({tag, "_mem_ena"}, mem_ena, 0);
    check({tag, "_mem_add"}, mem_add, 0);
    check({tag, "_mem_wea"}, mem_wea, 0);
    check({tag, "_cnt_reset"}, cnt_reset, 1);
  endtask

  // Start a build and play the histogram stage until cnt_sig_end is raised.
  task automatic kick(input bit force_err, input bit poke);
    logic [16*COUNT_BIT-1:0] blv;
    int mx;
    build_model(force_err);
    got.delete();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("clear_busy", busy, 1);
    check("clear_done", done, 0);
    check("clear_error", error, 0);
    check("clear_cnt_reset", cnt_reset, 1);
    @(negedge clock);
    check("count_cnt_reset", cnt_reset, 0);
    for (int i = 0; i < 4; i++) begin
      cnt_add = LEN_ADDRESS'($urandom_range(0, 63));
      cnt_ena = 1'($urandom_range(0, 1));
      start   = poke && (i == 1);
      #1;
      check("count_mem_add", mem_add, cnt_add);
      check("count_mem_ena", mem_ena, cnt_ena);
      check("count_mem_wea", mem_wea, 0);
      @(negedge clock);
    end
    start = 1'b0; cnt_ena = 1'b0; cnt_add = '0;
    blv = '0; mx = 0;
    for (int s = 0; s < INDEX_COUNT; s++) begin
      blv[int'(lens[s])*COUNT_BIT +: COUNT_BIT] = blv[int'(lens[s])*COUNT_BIT +: COUNT_BIT] + COUNT_BIT'(1);
      if (int'(lens[s]) > mx) mx = int'(lens[s]);
    end
    bl_count    = blv;
    cnt_max     = COUNT_BIT'(mx);
    cnt_error   = force_err;
    cnt_sig_end = 1'b1;
  endtask

  task automatic finish_build(input bit poke);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clock);
      n++;
      start = poke && (n == 20);
      if (done || error != 0) break;
    end
    start = 1'b0;
    check("latency", n, exp_lat);
    check("final_done", done, exp_err == 0);
    check("final_error", error, exp_err);
    check("final_busy", busy, 0);
    check("final_mem_ena", mem_ena, 0);
    @(negedge clock);
    check("held_error", error, exp_err);
    check("held_done", done, exp_err == 0);
    check("idle_code_we", code_we, 0);
    check("strobe_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check("strobe_addr", got[i].addr, exp_q[i].addr);
      check("strobe_code", got[i].code, exp_q[i].code);
      check("strobe_len", got[i].len, exp_q[i].len);
    end
    cnt_sig_end = 1'b0;
    cnt_error   = 1'b0;
  endtask

  task automatic set_example();
    for (int s = 0; s < INDEX_COUNT; s++) lens[s] = '0;
    for (int s = 0; s < 5; s++) lens[s] = 3'd3;
    lens[5] = 3'd2;
    lens[6] = 3'd4;
    lens[7] = 3'd4;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cnt_add = '0; cnt_ena = 1'b0;
    cnt_sig_end = 1'b0; cnt_error = 1'b0; cnt_max = '0; bl_count = '0;
    for (int s = 0; s < INDEX_COUNT; s++) lens[s] = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);
    check("idle_cnt_reset", cnt_reset, 0);
    check("idle_busy", busy, 0);

    // Worked example table.
    set_example();
    kick(0, 0);
    finish_build(0);
    if (got.size() == 8) begin
      check("example_s0_code", got[0].code, 7'b0000010);
      check("example_s5_code", got[5].code, 7'b0000000);
      check("example_s5_len", got[5].len, 2);
      check("example_s7_code", got[7].code, 7'b0001111);
    end

    // Empty code set.
    for (int s = 0; s < INDEX_COUNT; s++) lens[s] = '0;
    kick(0, 0);
    finish_build(0);

    // Oversubscribed at length 1.
    lens[0] = 3'd1; lens[1] = 3'd1; lens[2] = 3'd1;
    kick(0, 0);
    finish_build(0);

    // Histogram overflow.
    set_example();
    kick(1, 0);
    finish_build(0);

    // Reset while assigning symbol 10, then rebuild.
    kick(0, 0);
    repeat (39) @(negedge clock);
    check("pre_reset_mem_add", mem_add, 10);
    check("pre_reset_mem_ena", mem_ena, 1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    cnt_sig_end = 1'b0;
    @(negedge clock);
    check("post_reset_cnt_reset", cnt_reset, 0);
    kick(0, 0);
    finish_build(0);

    // Start pulses while busy are ignored; start after done rebuilds.
    kick(0, 1);
    finish_build(1);
    kick(0, 0);
    finish_build(0);

    // Randomized length sets.
    for (int t = 0; t < 8; t++) begin
      for (int s = 0; s < INDEX_COUNT; s++) begin
        if (t < 4) lens[s] = 3'($urandom_range(0, 7));
        else lens[s] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(3, 5));
      end
      kick(0, 0);
      finish_build(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huff_build_ctrl.md
Name: huff_build_ctrl

Overview:
- Sequencer for building the code-length Huffman table in the decompress path.
- Resets and runs the length-histogram stage (`count`), then shares the single-port length RAM with it.
- Computes canonical first codes per length, then rescans the RAM and emits one (symbol, code, length) write per non-zero-length symbol to the code table.
- Sits between the header parser (start) and the symbol decoder (done/error).

Parameters:
- INDEX_BIT, 4, symbol-index field width in a RAM word
- LEN_BIT, 3, code-length field width in a RAM word
- COUNT_BIT, 5, width of each per-length count from the histogram stage
- LEN_ADDRESS, 6, length-RAM address width
- INDEX_COUNT, 19, number of symbols stored in the length RAM
- MAX_LEN, 7, maximum code length (2^LEN_BIT-1)
- CODE_BIT, 7, canonical code width (= MAX_LEN)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to build a table; ignored unless idle/done/fail
- in_data  in  LEN_BIT+INDEX_BIT  length-RAM read data; length = in_data[LEN_BIT-1:0]
- mem_add  out  LEN_ADDRESS  length-RAM address (muxed)
- mem_ena  out  1  length-RAM enable (muxed)
- mem_wea  out  1  length-RAM write enable (always 0 from this block)
- cnt_reset  out  1  drives the histogram stage's reset
- cnt_add  in  LEN_ADDRESS  histogram stage address request
- cnt_ena  in  1  histogram stage enable request
- cnt_sig_end  in  1  histogram stage finished
- cnt_error  in  1  histogram stage count overflow
- cnt_max  in  COUNT_BIT  largest length seen
- bl_count  in  16*COUNT_BIT  flattened out_0..out_15; slice k = count of length k
- code_we  out  1  code-table write strobe
- code_addr  out  LEN_ADDRESS  symbol index (= RAM address)
- code_val  out  CODE_BIT  canonical code, MSB-first, not bit-reversed
- code_len  out  LEN_BIT  length of code_val
- busy  out  1  high from accepted start until DONE/FAIL
- done  out  1  level; table complete
- error  out  2  0 none, 1 count overflow, 2 oversubscribed, 3 empty code set

Behaviour:
- Reset: state IDLE; busy=0, done=0, error=0, code_we=0, code_addr=0, code_val=0, code_len=0, mem_ena=0, mem_add=0, mem_wea=0; next_code[] cleared. cnt_reset = reset | (state==CLEAR).
- IDLE/DONE/FAIL + start -> CLEAR; done and error cleared, busy=1. start while busy has no effect.
- CLEAR: 1 cycle, cnt_reset=1 -> COUNT.
- COUNT: mem_add/mem_ena follow cnt_add/cnt_ena combinationally; wait for cnt_sig_end=1 -> CHECK.
- CHECK (1 cycle):
  - cnt_error=1 -> FAIL, error=1.
  - Otherwise cnt_max=0 -> FAIL, error=3.
  - Otherwise -> NEXTCODE with code=0, bits=1.
- NEXTCODE: one length per cycle, bits=1..MAX_LEN.
  - code = (code + bl_count[bits-1]) << 1, with bl_count[0] forced to 0.
  - next_code[bits] = code.
  - If code + bl_count[bits] > 2^bits -> FAIL, error=2.
  - After bits=MAX_LEN -> ASSIGN.
- Arithmetic: code held in CODE_BIT+1 bits so the compare sees the carry.
- ASSIGN: per symbol s=0..INDEX_COUNT-1, three cycles:
  - ADDR: mem_add=s, mem_ena=1.
  - WAIT: RAM latency.
  - USE: if len=in_data[LEN_BIT-1:0] != 0, then code_we=1 for one cycle, code_addr=s, code_len=len, code_val=next_code[len][CODE_BIT-1:0], and next_code[len] increments. Zero length -> no strobe.
- After s=INDEX_COUNT-1 -> DONE: done=1, busy=0, mem_ena=0.
- FAIL: busy=0, error held, mem_ena=0; no further code_we.
- mem_wea=0 in every state.
- Latency: 1 + histogram time + 1 + MAX_LEN + 3*INDEX_COUNT cycles from start to done.
- Reset mid-operation: immediate return to IDLE with reset values; the histogram stage is reset through cnt_reset in the same cycle.

Decomposition:
- Shared package huff_pkg holds:
  - state encoding (IDLE, CLEAR, COUNT, CHECK, NEXTCODE, ASSIGN_ADDR, ASSIGN_WAIT, ASSIGN_USE, DONE, FAIL);
  - error codes ERR_NONE/ERR_COUNT/ERR_OVERSUB/ERR_EMPTY;
  - LEN_BIT, INDEX_BIT, MAX_LEN defaults.
- One natural sub-module: huff_next_code (next_code register file, iterate step and oversubscription compare, post-assign increment), instantiated once.

Test Plan:
- Lengths (3,3,3,3,3,2,4,4) at s=0..7, zeros at 8..18 -> 8 strobes: s0..4 codes 010,011,100,101,110 (len 3); s5=00 (len 2); s6=1110, s7=1111 (len 4); done=1, error=0.
- All 19 lengths zero -> no code_we, FAIL with error=3, done=0.
- Lengths 1,1,1 at s=0..2, rest 0 -> error=2 during NEXTCODE at bits=1; no code_we.
- cnt_error forced to 1 when cnt_sig_end rises -> FAIL, error=1, no NEXTCODE cycles.
- Reset asserted during ASSIGN at s=10 -> next cycle all outputs at reset values, cnt_reset=1; a new start rebuilds the identical table.
- start pulsed while busy -> ignored; start after done -> done clears, a second build produces the same strobes.
